// File: rtl/gate_ctrl_pkg.sv
// Shared definitions for the round-robin OR-unit arbiter: FSM state
// encoding and the default requester count / datapath width.
package gate_ctrl_pkg;

   // Default number of requesters sharing the OR unit (power of two, 2..8).
   localparam int unsigned DEF_N = 4;

   // Default operand / result width in bits.
   localparam int unsigned DEF_W = 8;

   // Arbiter FSM states: one operation occupies IDLE -> CALC -> DONE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : gate_ctrl_pkg

// File: rtl/or_gate_w.sv
// Shared W-bit OR datapath. Purely combinational; the arbiter registers
// its output, so this block adds no latency of its own.
module or_gate_w #(
   parameter int unsigned W = gate_ctrl_pkg::DEF_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   // One OR per bit lane; lanes are independent of each other.
   for (genvar gi = 0; gi < W; gi++) begin : g_lane
      assign y[gi] = a[gi] | b[gi];
   end

endmodule : or_gate_w

// File: rtl/or_gate_arbiter.sv
// Round-robin arbiter in front of a single shared OR unit. A winner is
// picked in IDLE by scanning req upward from the rotating pointer, its
// operands are latched, the OR result is registered in CALC, and DONE
// presents a one-cycle done pulse before the pointer advances past the
// winner. Each operation takes exactly three cycles.
module or_gate_arbiter
   import gate_ctrl_pkg::*;
#(
   parameter int unsigned N = DEF_N,
   parameter int unsigned W = DEF_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N*W-1:0]       a,
   input  logic [N*W-1:0]       b,
   output logic [N-1:0]         gnt,
   output logic                 busy,
   output logic                 done,
   output logic [$clog2(N)-1:0] done_id,
   output logic [W-1:0]         y
);

   localparam int unsigned IDW = $clog2(N);

   // Per-requester views of the packed operand buses.
   logic [W-1:0]   a_slice [N];
   logic [W-1:0]   b_slice [N];

   // Registered FSM state and datapath.
   state_t         state_q;
   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] win_q;
   logic [N-1:0]   gnt_q;
   logic           busy_q;
   logic           done_q;
   logic [IDW-1:0] done_id_q;
   logic [W-1:0]   y_q;
   logic [W-1:0]   op_a_q;
   logic [W-1:0]   op_b_q;

   // Combinational arbitration result and shared OR output.
   logic           win_found;
   logic [IDW-1:0] win_idx;
   logic [IDW-1:0] cand;
   logic [N-1:0]   win_onehot;
   logic [W-1:0]   y_d;

   for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign a_slice[gi] = a[gi*W +: W];
      assign b_slice[gi] = b[gi*W +: W];
   end

   // Scan req upward from ptr_q; N is a power of two, so the IDW-bit sum
   // wraps from N-1 back to 0 on its own.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      cand      = ptr_q;
      for (int k = 0; k < int'(N); k++) begin
         cand = ptr_q + IDW'(k);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;

   // The single OR unit only ever sees the latched operands, so operand
   // changes after the grant cannot reach y.
   or_gate_w #(
      .W (W)
   ) u_or (
      .a (op_a_q),
      .b (op_b_q),
      .y (y_d)
   );

   // FSM with registered outputs; reset wins over every state action and
   // drops any in-flight operation without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         win_q     <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         y_q       <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_found) begin
                  win_q   <= win_idx;
                  op_a_q  <= a_slice[win_idx];
                  op_b_q  <= b_slice[win_idx];
                  gnt_q   <= win_onehot;
                  busy_q  <= 1'b1;
                  state_q <= CALC;
               end
            end
            CALC: begin
               y_q       <= y_d;
               done_q    <= 1'b1;
               done_id_q <= win_q;
               state_q   <= DONE;
            end
            DONE: begin
               // req is not looked at here; the next pick happens in IDLE.
               done_q  <= 1'b0;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               ptr_q   <= win_q + IDW'(1);
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign done_id = done_id_q;
   assign y       = y_q;

endmodule : or_gate_arbiter

// File: tb/tb_or_gate_arbiter.sv
// Self-checking bench for or_gate_arbiter: directed scenarios followed by
// random operations, compared against a transaction-level round-robin model.
module tb_or_gate_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] a;
   logic [N*W-1:0] b;
   logic [N-1:0]   gnt;
   logic           busy;
   logic           done;
   logic [1:0]     done_id;
   logic [W-1:0]   y;

   int errors = 0;
   int checks = 0;

   // Reference model state: rotating pointer and last reported result.
   int         m_ptr = 0;
   int         m_id  = 0;
   logic [W-1:0] m_y = '0;

   or_gate_arbiter #(
      .N (N),
      .W (W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .a       (a),
      .b       (b),
      .gnt     (gnt),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .y       (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Round-robin pick: first set bit at or after p, wrapping around.
   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   // Called on a falling edge with the DUT in IDLE; r must be non-zero.
   task automatic do_op(input logic [N-1:0] r, input logic [N*W-1:0] av,
                        input logic [N*W-1:0] bv, input bit perturb, input bit drop);
      int           w;
      logic [W-1:0] ey;
      logic [N-1:0] eg;
      req = r;
      a   = av;
      b   = bv;
      w   = pick(r, m_ptr);
      ey  = av[w*W +: W] | bv[w*W +: W];
      eg  = N'(1) << w;
      @(negedge clk);
      check("gnt_calc", gnt, eg);
      check("busy_calc", busy, 1);
      check("done_calc", done, 0);
      check("y_hold_calc", y, m_y);
      if (perturb) begin
         a = $urandom;
         b = $urandom;
      end
      if (drop) req = '0;
      @(negedge clk);
      check("done_pulse", done, 1);
      check("done_id", done_id, w);
      check("y_result", y, ey);
      check("gnt_done", gnt, eg);
      check("busy_done", busy, 1);
      @(negedge clk);
      check("done_clear", done, 0);
      check("gnt_clear", gnt, 0);
      check("busy_clear", busy, 0);
      check("y_hold", y, ey);
      check("done_id_hold", done_id, w);
      m_y   = ey;
      m_id  = w;
      m_ptr = (w + 1) % N;
      $display("op req=%b winner=%0d y=%h perturb=%0d drop=%0d", r, w, ey, perturb, drop);
   endtask

   task automatic do_reset();
      req = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_ptr = 0;
      m_id  = 0;
      m_y   = '0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_gnt"}, gnt, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_done_id"}, done_id, 0);
      check({tag, "_y"}, y, 0);
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      a   = '0;
      b   = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;

      // Single request from requester 0.
      do_op(4'b0001, 32'h0000_000F, 32'h0000_00F0, 1'b0, 1'b0);
      check("single_y_ff", y, 8'hFF);

      // All requesting, held: 0,1,2,3,0 from a fresh pointer.
      do_reset();
      for (int i = 0; i < 5; i++)
         do_op(4'b1111, 32'h4030_2010, 32'h0403_0201, 1'b0, 1'b0);

      // Drive the pointer to 3, then 1001 must serve 3 then 0.
      do_op(4'b0100, 32'h5566_7788, 32'h0102_0304, 1'b0, 1'b0);
      do_op(4'b1001, 32'hC000_000C, 32'h0300_0030, 1'b0, 1'b0);
      do_op(4'b1001, 32'hC000_000C, 32'h0300_0030, 1'b0, 1'b0);
      // With ptr back at 1, 1011 must pick requester 1.
      do_op(4'b1011, 32'h0000_1100, 32'h0000_2200, 1'b0, 1'b0);

      // Operands changed after latching must not reach y.
      do_op(4'b0010, 32'h0000_A000, 32'h0000_0500, 1'b1, 1'b0);
      check("latched_y_a5", y, 8'hA5);

      // Reset in CALC aborts the operation; arbitration restarts at 0.
      req = 4'b1000;
      a   = 32'hFF00_0000;
      b   = 32'h00FF_0000;
      @(negedge clk);
      check("abort_gnt", gnt, 4'b1000);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      check_zero("abort");
      @(negedge clk);
      check_zero("abort_next");
      m_ptr = 0;
      m_id  = 0;
      m_y   = '0;
      do_op(4'b1010, 32'h0077_0066, 32'h0088_0011, 1'b0, 1'b0);

      // Idle: nothing happens and the result holds.
      req = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_busy", busy, 0);
         check("idle_done", done, 0);
         check("idle_y", y, m_y);
      end

      // Random operations with occasional operand changes, request drops
      // and idle gaps.
      for (int i = 0; i < 40; i++) begin
         do_op(N'($urandom_range(1, (1 << N) - 1)), $urandom, $urandom,
               1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) begin
            req = '0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            check("gap_busy", busy, 0);
            check("gap_y", y, m_y);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_or_gate_arbiter
